poly_mult_seq: RTL and testbench
================================

Name: poly_mult_seq

Overview:
Sequential polynomial multiplier controller. It multiplies two N-coefficient polynomials over Z/2^W using one shared W×W multiplier and accumulator. The result is reduced modulo x^N+1 (negacyclic) or x^N−1 (cyclic).
It gives the same coefficient results as the combinational PolyMult at a fraction of the area, and sits behind a valid/ready handshake so several producers can feed it via an upstream mux.

Parameters:
W, 8, coefficient width in bits; all arithmetic is mod 2^W
N, 4, number of coefficients per polynomial; must be a power of 2, ≥2

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands
a  input  N*W  polynomial A, coefficient k at bits [k*W +: W]
b  input  N*W  polynomial B, same packing
out_valid  output  1  result c valid
out_ready  input  1  consumer accepts result
c  output  N*W  product polynomial C, same packing
busy  output  1  high in MAC state

Behaviour:
- Reset is asynchronous and active-low on rst_n. While reset is asserted:
  - state=IDLE, out_valid=0, c=0, busy=0, in_ready=1
  - counters i,j=0; accumulators acc[0..N-1]=0; operand registers=0
- Reset asserted mid-operation aborts the operation. No partial result is ever presented.
- FSM states: IDLE, MAC, DONE.
  - IDLE: in_ready=1. On an edge with in_valid&in_ready: capture a,b into operand registers, clear acc, set i=j=0, go to MAC.
  - MAC: in_ready=0, busy=1. Each cycle computes p = a_reg[i]*b_reg[j], truncated to W bits, and k=(i+j) mod N.
    - If i+j<N, or cyclic mode: acc[k] += p.
    - Else (negacyclic wrap): acc[k] −= p.
    - All accumulation is mod 2^W.
    - j increments; on j=N−1, j wraps to 0 and i increments.
    - After the pass with i=j=N−1: copy acc to c, set out_valid=1, go to DONE. The final product is included in c.
  - DONE: out_valid=1, in_ready=0. c is held stable. On an edge with out_ready=1: out_valid=0, go to IDLE.
- Latency: exactly N*N cycles (16 at default) from the input-accept edge to the edge that raises out_valid. out_ready is never needed to start computation.
- Throughput: one result per N*N+2 cycles at best; inputs cannot be accepted in DONE.
- Backpressure: out_valid stays high and c stays constant indefinitely while out_ready=0.
- in_valid while not in IDLE is ignored; a and b may change freely once captured.
- out_ready while not in DONE is ignored.
- c retains its last value after the handshake until the next result overwrites it.
- Width rule: products and sums wrap mod 2^W. There are no saturation or overflow flags.

Optional Feature:
Macro POLY_NEGACYCLIC_EN.
- Defined: reduction mod x^N+1. Wrapped products (i+j≥N) are subtracted from acc[i+j−N].
- Not defined: reduction mod x^N−1 (cyclic). All products are added.
- Handshake, latency and ports are identical in both builds.

Test Plan:
1. Reset during MAC (assert rst_n=0 at cycle 5 after accept) -> out_valid=0, c=0, in_ready=1 immediately, without waiting for a clock edge. Next operation completes normally.
2. a: A0=1, A1=2, others 0; b: B0=3, B1=4, others 0 -> after exactly 16 cycles out_valid=1 with C0=3, C1=10, C2=8, C3=0 (both builds).
3. Wrap case A3=1, B1=1, all else 0:
   - POLY_NEGACYCLIC_EN defined -> C0=255, C1=C2=C3=0.
   - Undefined -> C0=1, C1=C2=C3=0.
4. Overflow, all other coefficients 0:
   - A0=255, B0=255 -> C0=1.
   - A0=16, B0=16 -> C0=0.
   - Remaining coefficients 0 in both cases.
5. Backpressure: hold out_ready=0 for 20 cycles after out_valid -> c and out_valid stable, in_ready=0, and a second in_valid pulse is ignored. Raise out_ready -> out_valid drops next edge, in_ready=1.
6. Back-to-back: drive in_valid continuously with 10 random operand sets, out_ready=1 -> every c matches the golden model and inter-accept spacing is 18 cycles.

Source files
------------

// File: rtl/poly_mult_seq.sv
// Sequential polynomial multiplier: one shared W x W MAC, N*N cycles per product.
// Define POLY_NEGACYCLIC_EN for reduction mod x^N+1; default build reduces mod x^N-1.
module poly_mult_seq #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] c,
  output logic           busy
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q [N];
  logic [W-1:0]    a_d [N];
  logic [W-1:0]    b_q [N];
  logic [W-1:0]    b_d [N];
  logic [W-1:0]    acc_q [N];
  logic [W-1:0]    acc_d [N];
  logic [W-1:0]    acc_nx [N];
  logic [IW-1:0]   i_q, i_d, j_q, j_d;
  logic [N*W-1:0]  c_q, c_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic [W-1:0]    p_c;
  logic [IW-1:0]   k_c;
  logic            wrap_c;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
      acc_q       <= '{default: '0};
      i_q         <= '0;
      j_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      j_q         <= j_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, MAC datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    i_d         = i_q;
    j_d         = j_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;

    p_c = a_q[i_q] * b_q[j_q];
`ifdef POLY_NEGACYCLIC_EN
    // Carry out of i+j marks a term that wraps past x^N and is negated.
    {wrap_c, k_c} = {1'b0, i_q} + {1'b0, j_q};
`else
    wrap_c = 1'b0;
    k_c    = i_q + j_q;
`endif
    acc_nx      = acc_q;
    acc_nx[k_c] = wrap_c ? (acc_q[k_c] - p_c) : (acc_q[k_c] + p_c);

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          for (int unsigned k = 0; k < N; k++) begin
            a_d[k] = a[k*W +: W];
            b_d[k] = b[k*W +: W];
          end
          acc_d   = '{default: '0};
          i_d     = '0;
          j_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_nx;
        j_d   = j_q + IW'(1);
        if (j_q == LAST) i_d = i_q + IW'(1);
        // Final pass: publish the accumulator including this cycle's product.
        if (i_q == LAST && j_q == LAST) begin
          for (int unsigned k = 0; k < N; k++) c_d[k*W +: W] = acc_nx[k];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d == S_MAC);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_poly_mult_seq.sv
// Scoreboard bench for poly_mult_seq: directed vectors plus a back-to-back burst.
module tb_poly_mult_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned NW = N * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] a, b;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] c;
  logic          busy;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            last_acc = -1;
  bit            b2b = 1'b0;
  bit            ov_prev = 1'b0;
  logic [NW-1:0] sb [$];

  poly_mult_seq #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: full linear convolution, then fold the upper half back.
  function automatic logic [NW-1:0] model(input logic [NW-1:0] av, input logic [NW-1:0] bv);
    int            full [2*N];
    logic [NW-1:0] r;
    for (int k = 0; k < 2*N; k++) full[k] = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        full[i+j] += int'(av[i*W +: W]) * int'(bv[j*W +: W]);
    for (int k = 0; k < N; k++) begin
`ifdef POLY_NEGACYCLIC_EN
      r[k*W +: W] = W'(full[k] - full[k+N]);
`else
      r[k*W +: W] = W'(full[k] + full[k+N]);
`endif
    end
    return r;
  endfunction

  // Monitor: accept tracking, latency/spacing checks and result scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        if (b2b && last_acc >= 0) chk("accept_spacing", 64'(cyc + 1 - last_acc), 64'd18);
        last_acc = cyc + 1;
      end
      if (out_valid && !ov_prev) chk("latency", 64'(cyc - last_acc), 64'(N*N));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 64'(c), 64'hdead_beef_0000);
        else chk("result_c", 64'(c), 64'(sb.pop_front()));
      end
    end
    ov_prev = out_valid;
  end

  // Called in the drive slot (#1 after a rising edge); returns in the same slot.
  task automatic send(input logic [NW-1:0] av, input logic [NW-1:0] bv,
                      input logic [NW-1:0] ev, input bit keep);
    int t = 0;
    a = av; b = bv; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    else sb.push_back(ev);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NW-1:0] av, bv, held_c;
    int t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_c", 64'(c), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Simple product, no wrap terms: (1+2x)(3+4x) = 3 + 10x + 8x^2
    send({8'd0, 8'd0, 8'd2, 8'd1}, {8'd0, 8'd0, 8'd4, 8'd3},
         {8'd0, 8'd8, 8'd10, 8'd3}, 1'b0);
    drain();

    // Reset five cycles into MAC: outputs clear without a clock edge
    send({8'd9, 8'd9, 8'd9, 8'd9}, {8'd7, 8'd7, 8'd7, 8'd7}, '0, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_c", 64'(c), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    void'(sb.pop_back());
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // All-ones operands after the abort
`ifdef POLY_NEGACYCLIC_EN
    send({4{8'd1}}, {4{8'd1}}, {8'd4, 8'd2, 8'd0, 8'd254}, 1'b0);
`else
    send({4{8'd1}}, {4{8'd1}}, {8'd4, 8'd4, 8'd4, 8'd4}, 1'b0);
`endif
    drain();

    // x^3 * x wraps to x^4
`ifdef POLY_NEGACYCLIC_EN
    send({8'd1, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd1, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd255}, 1'b0);
`else
    send({8'd1, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd1, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd1}, 1'b0);
`endif
    drain();

    // Coefficient overflow wraps mod 256
    send({24'd0, 8'd255}, {24'd0, 8'd255}, {24'd0, 8'd1}, 1'b0);
    send({24'd0, 8'd16}, {24'd0, 8'd16}, {24'd0, 8'd0}, 1'b0);
    drain();

    // Backpressure: result held 20 cycles, stray in_valid ignored
    out_ready = 1'b0;
    send({8'd0, 8'd0, 8'd1, 8'd3}, {8'd0, 8'd2, 8'd0, 8'd5},
         {8'd2, 8'd6, 8'd5, 8'd15}, 1'b0);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
    held_c = {8'd2, 8'd6, 8'd5, 8'd15};
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (n == 5) begin a = '1; b = '1; in_valid = 1'b1; end
      if (n == 6) in_valid = 1'b0;
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_c_stable", 64'(c), 64'(held_c));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_c_retained", 64'(c), 64'(held_c));
    repeat (30) @(posedge clk);
    #1;
    chk("bp_no_phantom_busy", 64'({busy, out_valid}), 64'd0);

    // Back-to-back burst with continuous in_valid
    last_acc = -1;
    b2b = 1'b1;
    for (int n = 0; n < 10; n++) begin
      av = NW'($urandom);
      bv = NW'($urandom);
      send(av, bv, model(av, bv), 1'b1);
    end
    in_valid = 1'b0;
    drain();
    b2b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
